// File: rtl/bram_dual_responder_pkg.sv
// Shared constants and access-request type for the dual-port BRAM responder.
package bram_dual_responder_pkg;

    localparam int BRAM_ADDR_W = 13;
    localparam int BRAM_DATA_W = 32;
    localparam int BRAM_LANES  = BRAM_DATA_W / 8;

    typedef struct packed {
        logic [BRAM_ADDR_W-1:0] addr;
        logic [BRAM_DATA_W-1:0] data;
        logic                   en;
        logic [BRAM_LANES-1:0]  we;
    } access_req_t;

    function automatic logic is_write(input access_req_t r);
        return r.en && (r.we != '0);
    endfunction

    function automatic logic is_read(input access_req_t r);
        return r.en && (r.we == '0);
    endfunction

endpackage

// File: rtl/bram_dual_responder_if.sv
// Host-side (A) and processing-side (B) access ports plus the collision flag.
interface bram_dual_responder_if
    import bram_dual_responder_pkg::*;
#(
    parameter int ADDR_W = BRAM_ADDR_W,
    parameter int DATA_W = BRAM_DATA_W
) ();
    localparam int LANES = DATA_W / 8;

    logic [ADDR_W-1:0] addra;
    logic [DATA_W-1:0] dina;
    logic              ena;
    logic [LANES-1:0]  wea;
    logic [DATA_W-1:0] douta;
    logic              douta_valid;

    logic [ADDR_W-1:0] addrb;
    logic [DATA_W-1:0] dinb;
    logic              enb;
    logic [LANES-1:0]  web;
    logic [DATA_W-1:0] doutb;
    logic              doutb_valid;

    logic              collision;

    modport master (
        output addra, dina, ena, wea, addrb, dinb, enb, web,
        input  douta, douta_valid, doutb, doutb_valid, collision
    );

    modport slave (
        input  addra, dina, ena, wea, addrb, dinb, enb, web,
        output douta, douta_valid, doutb, doutb_valid, collision
    );

endinterface

// File: rtl/bram_read_pipe.sv
// Read-return delay line: the word registered at the RAM output travels
// READ_LAT-1 further stages alongside its valid bit.
module bram_read_pipe #(
    parameter int READ_LAT = 2,
    parameter int DATA_W   = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              vld_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              vld_o,
    output logic [DATA_W-1:0] data_o
);

    if (READ_LAT <= 1) begin : g_pass
        assign vld_o  = vld_i;
        assign data_o = data_i;
    end else begin : g_shift
        localparam int D = READ_LAT - 1;

        logic [D:1]             vld_q;
        logic [D:1][DATA_W-1:0] data_q;

        for (genvar s = 1; s <= D; s++) begin : g_stage
            logic              prev_vld;
            logic [DATA_W-1:0] prev_data;

            if (s == 1) begin : g_first
                assign prev_vld  = vld_i;
                assign prev_data = data_i;
            end else begin : g_next
                assign prev_vld  = vld_q[s-1];
                assign prev_data = data_q[s-1];
            end

            // advance one stage; data moves only with a valid so the last stage holds its last return
            always_ff @(posedge CLK) begin
                if (RST) begin
                    vld_q[s]  <= 1'b0;
                    data_q[s] <= '0;
                end else begin
                    vld_q[s] <= prev_vld;
                    if (prev_vld) begin
                        data_q[s] <= prev_data;
                    end
                end
            end
        end

        assign vld_o  = vld_q[D];
        assign data_o = data_q[D];
    end

endmodule

// File: rtl/bram_dual_responder.sv
// True-dual-port word RAM with byte-lane writes, pipelined read returns per
// port, read-first cross-port behaviour and a sticky same-word write flag.
module bram_dual_responder
    import bram_dual_responder_pkg::*;
#(
    parameter int ADDR_W   = BRAM_ADDR_W,
    parameter int DATA_W   = BRAM_DATA_W,
    parameter int READ_LAT = 2
) (
    input  logic CLK,
    input  logic RST,
    bram_dual_responder_if.slave bus
);

    localparam int LANES = DATA_W / 8;
    localparam int IDX_W = ADDR_W - 2;
    localparam int DEPTH = 1 << IDX_W;

    access_req_t       req_a, req_b;
    logic [IDX_W-1:0]  idx_a, idx_b;
    logic              wr_a, wr_b, rd_a, rd_b;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              rd_vld_a_q, rd_vld_b_q;
    logic [DATA_W-1:0] rd_data_a_q, rd_data_b_q;
    logic              collision_q, collision_d;

    logic              douta_valid_w, doutb_valid_w;
    logic [DATA_W-1:0] douta_w, doutb_w;
    logic              unused_addr_lsbs;

    assign req_a = '{addr: bus.addra, data: bus.dina, en: bus.ena, we: bus.wea};
    assign req_b = '{addr: bus.addrb, data: bus.dinb, en: bus.enb, we: bus.web};

    assign idx_a = req_a.addr[ADDR_W-1:2];
    assign idx_b = req_b.addr[ADDR_W-1:2];
    assign unused_addr_lsbs = ^{req_a.addr[1:0], req_b.addr[1:0]};

    // anything presented while RST is high is dropped
    assign wr_a = !RST && is_write(req_a);
    assign wr_b = !RST && is_write(req_b);
    assign rd_a = !RST && is_read(req_a);
    assign rd_b = !RST && is_read(req_b);

    assign collision_d = collision_q | (wr_a && wr_b && (idx_a == idx_b));

    // lane writes; port A is applied last so its lanes win on a same-word clash
    always_ff @(posedge CLK) begin
        for (int l = 0; l < LANES; l++) begin
            if (wr_b && req_b.we[l]) begin
                mem[idx_b][l*8 +: 8] <= req_b.data[l*8 +: 8];
            end
            if (wr_a && req_a.we[l]) begin
                mem[idx_a][l*8 +: 8] <= req_a.data[l*8 +: 8];
            end
        end
    end

    // port A RAM output register (first latency stage, sees pre-write contents)
    always_ff @(posedge CLK) begin
        if (RST) begin
            rd_vld_a_q  <= 1'b0;
            rd_data_a_q <= '0;
        end else begin
            rd_vld_a_q <= rd_a;
            if (rd_a) begin
                rd_data_a_q <= mem[idx_a];
            end
        end
    end

    // port B RAM output register (first latency stage, sees pre-write contents)
    always_ff @(posedge CLK) begin
        if (RST) begin
            rd_vld_b_q  <= 1'b0;
            rd_data_b_q <= '0;
        end else begin
            rd_vld_b_q <= rd_b;
            if (rd_b) begin
                rd_data_b_q <= mem[idx_b];
            end
        end
    end

    // sticky same-word dual-write flag
    always_ff @(posedge CLK) begin
        if (RST) begin
            collision_q <= 1'b0;
        end else begin
            collision_q <= collision_d;
        end
    end

    bram_read_pipe #(.READ_LAT(READ_LAT), .DATA_W(DATA_W)) u_pipe_a (
        .CLK    (CLK),
        .RST    (RST),
        .vld_i  (rd_vld_a_q),
        .data_i (rd_data_a_q),
        .vld_o  (douta_valid_w),
        .data_o (douta_w)
    );

    bram_read_pipe #(.READ_LAT(READ_LAT), .DATA_W(DATA_W)) u_pipe_b (
        .CLK    (CLK),
        .RST    (RST),
        .vld_i  (rd_vld_b_q),
        .data_i (rd_data_b_q),
        .vld_o  (doutb_valid_w),
        .data_o (doutb_w)
    );

    assign bus.douta       = douta_w;
    assign bus.douta_valid = douta_valid_w;
    assign bus.doutb       = doutb_w;
    assign bus.doutb_valid = doutb_valid_w;
    assign bus.collision   = collision_q;

endmodule

// File: tb/tb_bram_dual_responder.sv
// Bench: three responders (READ_LAT 1, 2, 4) share one stimulus stream and are
// compared against a cycle-indexed reference of the memory and read returns.
module tb_bram_dual_responder;

    localparam int NDUT = 3;
    localparam int HIST = 1024;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [12:0] addra, addrb;
    logic [31:0] dina, dinb;
    logic        ena, enb;
    logic [3:0]  wea, web;

    logic [31:0] got_douta [NDUT];
    logic [31:0] got_doutb [NDUT];
    logic        got_va    [NDUT];
    logic        got_vb    [NDUT];
    logic        got_coll  [NDUT];

    bram_dual_responder_if bus [NDUT] ();

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        bram_dual_responder #(.READ_LAT((g == 0) ? 1 : ((g == 1) ? 2 : 4))) u_dut (
            .CLK (clk),
            .RST (rst),
            .bus (bus[g])
        );
        assign bus[g].addra = addra;
        assign bus[g].dina  = dina;
        assign bus[g].ena   = ena;
        assign bus[g].wea   = wea;
        assign bus[g].addrb = addrb;
        assign bus[g].dinb  = dinb;
        assign bus[g].enb   = enb;
        assign bus[g].web   = web;
        assign got_douta[g] = bus[g].douta;
        assign got_doutb[g] = bus[g].doutb;
        assign got_va[g]    = bus[g].douta_valid;
        assign got_vb[g]    = bus[g].doutb_valid;
        assign got_coll[g]  = bus[g].collision;
    end

    // reference: word array, per-edge record of reads issued, last returned values
    logic [31:0] mem_m [16];
    bit          coll_m;
    bit          ha_v [HIST];
    bit          hb_v [HIST];
    logic [31:0] ha_d [HIST];
    logic [31:0] hb_d [HIST];
    logic [31:0] last_a [NDUT];
    logic [31:0] last_b [NDUT];
    bit          exp_va [NDUT];
    bit          exp_vb [NDUT];
    int          cyc;
    int          n_checks;
    int          n_pass;

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : ((d == 1) ? 2 : 4);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] we);
        logic [31:0] r;
        r = old_w;
        for (int l = 0; l < 4; l++) begin
            if (we[l]) r[l*8 +: 8] = new_w[l*8 +: 8];
        end
        return r;
    endfunction

    task automatic tick();
        int ia;
        int ib;
        int k;
        cyc++;
        if (cyc >= HIST - 1) begin
            $display("FAIL cycle_budget got %0d want below %0d", cyc, HIST - 1);
            $fatal(1, "cycle budget exhausted");
        end
        ia = int'(addra[5:2]);
        ib = int'(addrb[5:2]);
        if (rst) begin
            coll_m = 1'b0;
            for (int i = 0; i <= cyc; i++) begin
                ha_v[i] = 1'b0;
                hb_v[i] = 1'b0;
            end
        end else begin
            ha_v[cyc] = ena && (wea == 4'h0);
            hb_v[cyc] = enb && (web == 4'h0);
            ha_d[cyc] = mem_m[ia];
            hb_d[cyc] = mem_m[ib];
            if (ena && enb && wea != 4'h0 && web != 4'h0 && ia == ib) coll_m = 1'b1;
            if (enb && web != 4'h0) mem_m[ib] = merge(mem_m[ib], dinb, web);
            if (ena && wea != 4'h0) mem_m[ia] = merge(mem_m[ia], dina, wea);
        end
        @(posedge clk);
        #1;
        for (int d = 0; d < NDUT; d++) begin
            k = cyc - lat_of(d) + 1;
            exp_va[d] = !rst && k >= 1 && ha_v[k];
            exp_vb[d] = !rst && k >= 1 && hb_v[k];
            if (rst) begin
                last_a[d] = 32'h0;
                last_b[d] = 32'h0;
            end else begin
                if (exp_va[d]) last_a[d] = ha_d[k];
                if (exp_vb[d]) last_b[d] = hb_d[k];
            end
        end
    endtask

    task automatic idle();
        ena = 1'b0;
        enb = 1'b0;
        wea = 4'h0;
        web = 4'h0;
    endtask

    task automatic set_a(input logic [12:0] a, input logic [31:0] d, input logic [3:0] we);
        ena = 1'b1; addra = a; dina = d; wea = we;
    endtask

    task automatic set_b(input logic [12:0] a, input logic [31:0] d, input logic [3:0] we);
        enb = 1'b1; addrb = a; dinb = d; web = we;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_a(13'h010, 32'h12345678, 4'hF);
        set_b(13'h014, 32'h0, 4'h0);
        repeat (3) tick();
        for (int d = 0; d < NDUT; d++) begin
            n_checks++;
            if (got_douta[d] !== 32'h0) $display("FAIL reset_douta L=%0d got %h want 0", lat_of(d), got_douta[d]);
            else n_pass++;
            n_checks++;
            if (got_doutb[d] !== 32'h0) $display("FAIL reset_doutb L=%0d got %h want 0", lat_of(d), got_doutb[d]);
            else n_pass++;
            n_checks++;
            if (got_va[d] !== 1'b0) $display("FAIL reset_va L=%0d got %b want 0", lat_of(d), got_va[d]);
            else n_pass++;
            n_checks++;
            if (got_vb[d] !== 1'b0) $display("FAIL reset_vb L=%0d got %b want 0", lat_of(d), got_vb[d]);
            else n_pass++;
            n_checks++;
            if (got_coll[d] !== 1'b0) $display("FAIL reset_coll L=%0d got %b want 0", lat_of(d), got_coll[d]);
            else n_pass++;
        end
        rst = 1'b0;
        idle();
    endtask

    task automatic test_init();
        for (int w = 0; w < 16; w++) begin
            set_b(13'(w * 4), $urandom, 4'hF);
            tick();
            for (int d = 0; d < NDUT; d++) begin
                n_checks++;
                if (got_vb[d] !== 1'b0 || got_doutb[d] !== 32'h0)
                    $display("FAIL write_no_strobe L=%0d got v=%b d=%h want v=0 d=0", lat_of(d), got_vb[d], got_doutb[d]);
                else n_pass++;
            end
        end
        idle();
    endtask

    task automatic test_write_read();
        set_b(13'h010, 32'hDEADBEEF, 4'hF);
        tick();
        set_b(13'h013, $urandom, 4'h0);
        tick();
        idle();
        for (int j = 0; j < 6; j++) begin
            for (int d = 0; d < NDUT; d++) begin
                n_checks++;
                if (got_vb[d] !== 1'(j == lat_of(d) - 1))
                    $display("FAIL wr_rd_valid L=%0d step %0d got %b want %b", lat_of(d), j, got_vb[d], j == lat_of(d) - 1);
                else n_pass++;
                if (j >= lat_of(d) - 1) begin
                    n_checks++;
                    if (got_doutb[d] !== 32'hDEADBEEF)
                        $display("FAIL wr_rd_data L=%0d step %0d got %h want deadbeef", lat_of(d), j, got_doutb[d]);
                    else n_pass++;
                end
            end
            tick();
        end
    endtask

    task automatic test_lanes();
        set_a(13'h020, 32'h11223344, 4'hF);
        tick();
        set_a(13'h020, 32'hAABBCCDD, 4'b0101);
        tick();
        set_a(13'h021, 32'h0, 4'h0);
        tick();
        idle();
        for (int j = 0; j < 6; j++) begin
            for (int d = 0; d < NDUT; d++) begin
                n_checks++;
                if (got_va[d] !== 1'(j == lat_of(d) - 1))
                    $display("FAIL lane_valid L=%0d step %0d got %b want %b", lat_of(d), j, got_va[d], j == lat_of(d) - 1);
                else n_pass++;
                if (j >= lat_of(d) - 1) begin
                    n_checks++;
                    if (got_douta[d] !== 32'h11BB33DD)
                        $display("FAIL lane_data L=%0d got %h want 11bb33dd", lat_of(d), got_douta[d]);
                    else n_pass++;
                end
            end
            tick();
        end
    endtask

    task automatic test_collision();
        set_a(13'h00C, $urandom, 4'hF);
        set_b(13'h014, $urandom, 4'hF);
        tick();
        idle();
        for (int d = 0; d < NDUT; d++) begin
            n_checks++;
            if (got_coll[d] !== 1'b0) $display("FAIL coll_diff_word L=%0d got %b want 0", lat_of(d), got_coll[d]);
            else n_pass++;
        end
        set_a(13'h004, 32'h1, 4'hF);
        set_b(13'h004, 32'h2, 4'hF);
        tick();
        idle();
        for (int d = 0; d < NDUT; d++) begin
            n_checks++;
            if (got_coll[d] !== 1'b1) $display("FAIL coll_set L=%0d got %b want 1", lat_of(d), got_coll[d]);
            else n_pass++;
        end
        set_a(13'h008, 32'h0000AAAA, 4'b0011);
        set_b(13'h00B, 32'hBBBBBBBB, 4'hF);
        tick();
        set_a(13'h008, 32'h0, 4'h0);
        set_b(13'h004, 32'h0, 4'h0);
        tick();
        idle();
        for (int j = 0; j < 6; j++) begin
            for (int d = 0; d < NDUT; d++) begin
                n_checks++;
                if (got_coll[d] !== 1'b1) $display("FAIL coll_sticky L=%0d step %0d got %b want 1", lat_of(d), j, got_coll[d]);
                else n_pass++;
                if (j == lat_of(d) - 1) begin
                    n_checks++;
                    if (got_doutb[d] !== 32'h1) $display("FAIL coll_a_wins L=%0d got %h want 1", lat_of(d), got_doutb[d]);
                    else n_pass++;
                    n_checks++;
                    if (got_douta[d] !== 32'hBBBBAAAA)
                        $display("FAIL coll_lane_mix L=%0d got %h want bbbbaaaa", lat_of(d), got_douta[d]);
                    else n_pass++;
                end
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic        rec_v [NDUT][8];
        logic [31:0] rec_d [NDUT][8];
        bit          ev;
        set_b(13'h000, 32'h1, 4'hF); tick();
        set_b(13'h004, 32'h2, 4'hF); tick();
        set_b(13'h008, 32'h3, 4'hF); tick();
        for (int j = 0; j < 8; j++) begin
            if (j < 3) set_b(13'(j * 4), 32'h0, 4'h0);
            else idle();
            tick();
            for (int d = 0; d < NDUT; d++) begin
                rec_v[d][j] = got_vb[d];
                rec_d[d][j] = got_doutb[d];
            end
        end
        for (int d = 0; d < NDUT; d++) begin
            for (int j = 0; j < 8; j++) begin
                ev = (j >= lat_of(d) - 1) && (j < lat_of(d) + 2);
                n_checks++;
                if (rec_v[d][j] !== ev)
                    $display("FAIL b2b_valid L=%0d step %0d got %b want %b", lat_of(d), j, rec_v[d][j], ev);
                else n_pass++;
                if (ev) begin
                    n_checks++;
                    if (rec_d[d][j] !== 32'(j - lat_of(d) + 2))
                        $display("FAIL b2b_data L=%0d step %0d got %h want %0d", lat_of(d), j, rec_d[d][j], j - lat_of(d) + 2);
                    else n_pass++;
                end
            end
        end
    endtask

    task automatic test_reset_inflight();
        set_b(13'h010, 32'h0, 4'h0);
        tick();
        for (int d = 0; d < NDUT; d++) begin
            n_checks++;
            if (got_vb[d] !== exp_vb[d]) $display("FAIL inflight_pre L=%0d got %b want %b", lat_of(d), got_vb[d], exp_vb[d]);
            else n_pass++;
        end
        rst = 1'b1;
        set_a(13'h010, 32'h0BADF00D, 4'hF);
        set_b(13'h010, 32'h0, 4'h0);
        tick();
        for (int d = 0; d < NDUT; d++) begin
            n_checks++;
            if (got_vb[d] !== 1'b0 || got_va[d] !== 1'b0 || got_doutb[d] !== 32'h0 || got_douta[d] !== 32'h0)
                $display("FAIL inflight_rst_out L=%0d got va=%b vb=%b a=%h b=%h want all 0", lat_of(d),
                         got_va[d], got_vb[d], got_douta[d], got_doutb[d]);
            else n_pass++;
            n_checks++;
            if (got_coll[d] !== 1'b0) $display("FAIL inflight_coll_clr L=%0d got %b want 0", lat_of(d), got_coll[d]);
            else n_pass++;
        end
        rst = 1'b0;
        idle();
        for (int j = 0; j < 5; j++) begin
            tick();
            for (int d = 0; d < NDUT; d++) begin
                n_checks++;
                if (got_vb[d] !== 1'b0 || got_doutb[d] !== 32'h0)
                    $display("FAIL inflight_discard L=%0d step %0d got v=%b d=%h want v=0 d=0", lat_of(d), j, got_vb[d], got_doutb[d]);
                else n_pass++;
            end
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_b(13'h010, 32'h0, 4'h0);
        tick();
        idle();
        for (int j = 0; j < 6; j++) begin
            for (int d = 0; d < NDUT; d++) begin
                n_checks++;
                if (got_vb[d] !== 1'(j == lat_of(d) - 1))
                    $display("FAIL post_rst_valid L=%0d step %0d got %b want %b", lat_of(d), j, got_vb[d], j == lat_of(d) - 1);
                else n_pass++;
                if (j >= lat_of(d) - 1) begin
                    n_checks++;
                    if (got_doutb[d] !== 32'hDEADBEEF)
                        $display("FAIL post_rst_intact L=%0d got %h want deadbeef", lat_of(d), got_doutb[d]);
                    else n_pass++;
                end
            end
            tick();
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            rst   = ($urandom_range(0, 63) == 0);
            ena   = 1'($urandom_range(0, 1));
            enb   = 1'($urandom_range(0, 1));
            wea   = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
            web   = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
            addra = {7'b0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
            addrb = {7'b0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
            if ($urandom_range(0, 3) == 0) addrb = {addra[12:2], 2'($urandom_range(0, 3))};
            dina  = $urandom;
            dinb  = $urandom;
            tick();
            for (int d = 0; d < NDUT; d++) begin
                n_checks++;
                if (got_va[d] !== exp_va[d]) $display("FAIL rnd_va L=%0d cyc %0d got %b want %b", lat_of(d), cyc, got_va[d], exp_va[d]);
                else n_pass++;
                n_checks++;
                if (got_douta[d] !== last_a[d]) $display("FAIL rnd_douta L=%0d cyc %0d got %h want %h", lat_of(d), cyc, got_douta[d], last_a[d]);
                else n_pass++;
                n_checks++;
                if (got_vb[d] !== exp_vb[d]) $display("FAIL rnd_vb L=%0d cyc %0d got %b want %b", lat_of(d), cyc, got_vb[d], exp_vb[d]);
                else n_pass++;
                n_checks++;
                if (got_doutb[d] !== last_b[d]) $display("FAIL rnd_doutb L=%0d cyc %0d got %h want %h", lat_of(d), cyc, got_doutb[d], last_b[d]);
                else n_pass++;
                n_checks++;
                if (got_coll[d] !== coll_m) $display("FAIL rnd_coll L=%0d cyc %0d got %b want %b", lat_of(d), cyc, got_coll[d], coll_m);
                else n_pass++;
            end
        end
        rst = 1'b0;
        idle();
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        cyc      = 0;
        coll_m   = 1'b0;
        for (int d = 0; d < NDUT; d++) begin
            last_a[d] = 32'h0;
            last_b[d] = 32'h0;
            exp_va[d] = 1'b0;
            exp_vb[d] = 1'b0;
        end
        rst   = 1'b1;
        addra = 13'h0;
        addrb = 13'h0;
        dina  = 32'h0;
        dinb  = 32'h0;
        idle();

        test_reset();
        test_init();
        test_write_read();
        test_lanes();
        test_collision();
        test_back_to_back();
        test_reset_inflight();
        test_random();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
